// File: rtl/rip_lsu_pkg.sv
// Shared types for the rip-cpu load/store unit: one-hot decoded instruction,
// LSU FSM states, access sizes and small decode helpers.
package rip_lsu_pkg;

  typedef struct packed {
    logic alu;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } inst_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_e;

  function automatic logic is_mem(input inst_t i);
    return i.lb | i.lh | i.lw | i.lbu | i.lhu | i.sb | i.sh | i.sw;
  endfunction

  function automatic logic is_store(input inst_t i);
    return i.sb | i.sh | i.sw;
  endfunction

  function automatic mem_size_e mem_size(input inst_t i);
    if (i.lb | i.lbu | i.sb)      return MEM_B;
    else if (i.lh | i.lhu | i.sh) return MEM_H;
    else                          return MEM_W;
  endfunction

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic misaligned(input inst_t i, input logic [1:0] a);
    return ((i.lh | i.lhu | i.sh) & a[0]) | ((i.lw | i.sw) & (a != 2'b00));
  endfunction

endpackage

// File: rtl/rip_lsu_align.sv
// Combinational lane logic: store strobes/replication and load lane
// extraction with sign/zero extension.
module rip_lsu_align
  import rip_lsu_pkg::*;
(
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wstrb      = 4'b1111;
    lane_wdata = wdata;
    load_data  = rdata;
    case (size)
      MEM_B: begin
        wstrb      = 4'b0001 << offset;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        wstrb      = 4'b0011 << {offset[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rip_lsu.sv
// Load/store unit between the execute-stage ALU and writeback, driving a
// req/gnt/rvalid data-memory port. Optional trap: RIP_LSU_MISALIGN_TRAP_EN.
module rip_lsu
  import rip_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  inst_t                 inst,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_wstrb,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
`ifdef RIP_LSU_MISALIGN_TRAP_EN
  ,
  output logic                  misalign,
  output logic [DATA_WIDTH-1:0] badaddr
`endif
);

  lsu_state_e            state_q, state_d;
  mem_size_e             size_q;
  logic                  uns_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  mem_go;
  logic                  trap_go;
  logic [3:0]            strb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;

  assign mem_go = start && is_mem(inst) && !inst.alu;
`ifdef RIP_LSU_MISALIGN_TRAP_EN
  assign trap_go = mem_go && misaligned(inst, addr[1:0]);
`else
  assign trap_go = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (mem_go && !trap_go) ? REQ : RESP;
      REQ:     if (dmem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT:    if (dmem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == IDLE);
    done     = (state_q == RESP);
    dmem_req = (state_q == REQ);
  end

  // Request fields are latched once in IDLE so they stay stable while REQ waits for gnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q    <= MEM_B;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        if (mem_go && !trap_go) begin
          size_q  <= mem_size(inst);
          uns_q   <= inst.lbu | inst.lhu;
          we_q    <= is_store(inst);
          addr_q  <= addr;
          wdata_q <= wdata;
        end else if (!mem_go) begin
          rd_data_q <= addr;
        end
      end
      if (state_q == REQ && dmem_gnt && we_q) rd_data_q <= '0;
      if (state_q == WAIT && dmem_rvalid)     rd_data_q <= load_data;
    end
  end

`ifdef RIP_LSU_MISALIGN_TRAP_EN
  logic                  misalign_q;
  logic [DATA_WIDTH-1:0] badaddr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
    end else begin
      if (state_d == RESP) misalign_q <= trap_go;
      if (trap_go)         badaddr_q  <= addr;
    end
  end

  assign misalign = misalign_q;
  assign badaddr  = badaddr_q;
`endif

  rip_lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (dmem_rdata),
    .wstrb       (strb),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  assign rd_data    = rd_data_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wstrb = we_q ? strb : 4'b0000;
  assign dmem_wdata = lane_wdata;

endmodule

// File: tb/tb_rip_lsu.sv
// Scoreboard bench for rip_lsu with a cycle-stepped data-memory responder.
// Trap scenarios are compiled in when RIP_LSU_MISALIGN_TRAP_EN is defined.
module tb_rip_lsu;
  import rip_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  inst_t       inst;
  logic [31:0] addr, wdata;
  logic        ready, done;
  logic [31:0] rd_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
`ifdef RIP_LSU_MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] badaddr;
`endif

  localparam inst_t I_ALU = inst_t'(9'b1_0000_0000);
  localparam inst_t I_LB  = inst_t'(9'b0_1000_0000);
  localparam inst_t I_LH  = inst_t'(9'b0_0100_0000);
  localparam inst_t I_LW  = inst_t'(9'b0_0010_0000);
  localparam inst_t I_LBU = inst_t'(9'b0_0001_0000);
  localparam inst_t I_LHU = inst_t'(9'b0_0000_1000);
  localparam inst_t I_SB  = inst_t'(9'b0_0000_0100);
  localparam inst_t I_SH  = inst_t'(9'b0_0000_0010);
  localparam inst_t I_SW  = inst_t'(9'b0_0000_0001);

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  rip_lsu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inst        (inst),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .done        (done),
    .rd_data     (rd_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign),
    .badaddr     (badaddr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_strb(input inst_t i, input logic [31:0] a);
    if (i.sb) return 4'b0001 << a[1:0];
    if (i.sh) return a[1] ? 4'b1100 : 4'b0011;
    if (i.sw) return 4'b1111;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] model_wd(input inst_t i, input logic [31:0] wd);
    if (i.sb) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (i.sh) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_rd(input inst_t i, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] sh_b, sh_h;
    sh_b = rdata >> (8 * a[1:0]);
    sh_h = rdata >> (a[1] ? 16 : 0);
    if (i.sb | i.sh | i.sw) return 32'h0;
    if (i.lb)  return {{24{sh_b[7]}}, sh_b[7:0]};
    if (i.lbu) return {24'h0, sh_b[7:0]};
    if (i.lh)  return {{16{sh_h[15]}}, sh_h[15:0]};
    if (i.lhu) return {16'h0, sh_h[15:0]};
    if (i.lw)  return rdata;
    return a;
  endfunction

  // Drives one instruction, plays the memory side, and scores the result at done.
  task automatic run_op(input string tag, input inst_t i, input logic [31:0] a, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    logic        st, ld, trap, got_done, granted;
    int          lat, exp_lat, req_cnt, rv_cnt;
    logic [31:0] exp_rd, held;
    st = i.sb | i.sh | i.sw;
    ld = i.lb | i.lh | i.lw | i.lbu | i.lhu;
    trap = 1'b0;
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    trap = ((i.lh | i.lhu | i.sh) && a[0]) || ((i.lw | i.sw) && a[1:0] != 2'b00);
`endif
    exp_rd  = trap ? last_rd : model_rd(i, a, rdata);
    exp_lat = (trap || !(st || ld)) ? 1 : (st ? gdly + 2 : gdly + rdly + 3);
    exp_q.push_back(exp_rd);
    got_done = 1'b0; granted = 1'b0; lat = 0; req_cnt = 0; rv_cnt = 0;

    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    start = 1'b1; inst = i; addr = a; wdata = wd;
    @(posedge clk);
    #1 start = 1'b0; inst = inst_t'(9'h0);

    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (done) begin
        got_done = 1'b1; lat = cyc;
        break;
      end
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
          check({tag, "_we"}, 32'(dmem_we), 32'(st));
          check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(model_strb(i, a)));
          if (st) check({tag, "_wdata"}, dmem_wdata, model_wd(i, wd));
        end
        if (req_cnt > gdly) begin
          dmem_gnt = 1'b1; granted = 1'b1;
        end
      end else if (granted && ld) begin
        if (rv_cnt == rdly) begin
          dmem_rvalid = 1'b1; dmem_rdata = rdata;
        end
        rv_cnt++;
      end
    end

    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_rd"}, rd_data, exp_q.pop_front());
    if (got_done) begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_req_cycles"}, req_cnt, ((st || ld) && !trap) ? gdly + 1 : 0);
`ifdef RIP_LSU_MISALIGN_TRAP_EN
      check({tag, "_misalign"}, 32'(misalign), 32'(trap));
      if (trap) check({tag, "_badaddr"}, badaddr, a);
`endif
      held = rd_data;
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_rd_hold"}, rd_data, exp_rd);
      if (held !== exp_rd) last_rd = held;
    end
    last_rd = exp_rd;
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; inst = inst_t'(9'h0); addr = '0; wdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", rd_data, 32'h0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_daddr", dmem_addr, 32'h0);
    check("rst_dwdata", dmem_wdata, 32'h0);
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_badaddr", badaddr, 32'h0);
`endif
    rst_n = 1'b1;

    run_op("sw",   I_SW,  32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_op("sb",   I_SB,  32'h103, 32'h000000A5, 0, 0, 32'h0);
    run_op("sh",   I_SH,  32'h102, 32'h1234CAFE, 1, 0, 32'h0);
    run_op("lb",   I_LB,  32'h102, 32'h0,        0, 0, 32'h12F03456);
    run_op("lbu",  I_LBU, 32'h102, 32'h0,        0, 0, 32'h12F03456);
    run_op("lh",   I_LH,  32'h102, 32'h0,        3, 0, 32'h8001ABCD);
    run_op("lhu",  I_LHU, 32'h100, 32'h0,        0, 2, 32'h8001ABCD);
    run_op("lw",   I_LW,  32'h10C, 32'h0,        1, 1, 32'hCAFEF00D);
    run_op("add",  I_ALU, 32'h55,  32'h0,        0, 0, 32'h0);

    // Reset while waiting for read data: the late rvalid must not produce done.
    @(negedge clk);
    start = 1'b1; inst = I_LW; addr = 32'h200;
    @(posedge clk);
    #1 start = 1'b0; inst = inst_t'(9'h0);
    @(negedge clk);
    check("abort_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("abort_wait_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_rd", rd_data, 32'h0);
    check("abort_req_low", 32'(dmem_req), 32'd0);
    last_rd = 32'h0;

    run_op("add2", I_ALU, 32'h77, 32'h0, 0, 0, 32'h0);
    // Misaligned accesses: trapped when the option is built in, otherwise low bits dropped.
    run_op("lw_mis",  I_LW,  32'h101, 32'h0,      0, 0, 32'hA1B2C3D4);
    run_op("lh_odd",  I_LH,  32'h103, 32'h0,      0, 0, 32'h7FFE0001);
    run_op("sw_mis",  I_SW,  32'h106, 32'h0BADF00D, 0, 0, 32'h0);
    run_op("lbu_end", I_LBU, 32'h3FF, 32'h0,      0, 0, 32'h80FFFF7F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
